// File: rtl/kim_tty_pkg.sv
// kim_tty_pkg: shared types and constants for the KIM-1 teletype bridge.
//   rx_state_t / tx_state_t : serial frame FSM states (idle, start, data, stop)
//   DATA_BITS               : data bits per frame (no parity)
//   BIT_IDX_W               : width of the data-bit index counters
package kim_tty_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  // Enumerators are prefixed because both FSM types share this package scope.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/kim_bit_timer.sv
// kim_bit_timer: loadable down-counter used for serial bit timing.
//   clk, reset : clock, asynchronous active-low reset
//   load       : start (or restart) a count from load_val
//   load_val   : cycles-minus-one until tc
//   tc         : high for one cycle when a running count reaches 0
// After tc the timer stops unless it is reloaded in the same cycle, so the
// owning FSM never sees a stray terminal count while idle.
module kim_bit_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         run_q, run_d;

  assign tc = run_q && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load) begin
      cnt_d = load_val;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/kim_tty_bridge.sv
// kim_tty_bridge: host-side far end of the KIM-1 teletype link.
//   clk, reset        : system clock, asynchronous active-low reset
//   tty_rx            : serial in from KIM-1 TTYO (idle high, asynchronous)
//   tty_tx            : serial out to KIM-1 TTYI (idle high)
//   rx_data/rx_valid  : received byte holding register, consumed on rx_ready
//   rx_ferr           : 1-cycle pulse, stop bit was 0, byte discarded
//   rx_overrun        : 1-cycle pulse, byte completed while register full
//   tx_data/tx_valid  : byte offered for transmission
//   tx_ready/tx_busy  : transmitter idle / frame in progress
// Frames are 8N1 on receive, 8N<STOP_BITS> on transmit, LSB first.
module kim_tty_bridge
  import kim_tty_pkg::*;
#(
  parameter int BIT_CYCLES = 104,
  parameter int STOP_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tty_rx,
  output logic                 tty_tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_ferr,
  output logic                 rx_overrun,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0]     FULL_LD   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     HALF_LD   = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);

  // ---------------------------------------------------------------- RX ----
  // Two-flop synchroniser plus one history flop for edge detection; all
  // preset high so reset release never looks like a start edge.
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= tty_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  rx_state_t              rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0]   rx_sh_q, rx_sh_d;
  logic [BIT_IDX_W-1:0]   rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_ferr_q, rx_ferr_d;
  logic                   rx_ovr_q, rx_ovr_d;
  logic                   rx_ld, rx_tc, rx_done;
  logic [CNT_W-1:0]       rx_ld_val;

  kim_bit_timer #(.W(CNT_W)) u_rx_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (rx_ld),
    .load_val (rx_ld_val),
    .tc       (rx_tc)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_sh_d    = rx_sh_q;
    rx_bit_d   = rx_bit_q;
    rx_ld      = 1'b0;
    rx_ld_val  = FULL_LD;
    rx_done    = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // Half-bit delay puts every later sample near mid-bit.
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_ld      = 1'b1;
          rx_ld_val  = HALF_LD;
        end
      end
      RX_START: begin
        if (rx_tc) begin
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;          // glitch, not a real start bit
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
            rx_ld      = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (rx_tc) begin
          rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          rx_ld   = 1'b1;
          if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_tc) begin
          rx_state_d = RX_IDLE;
          if (rx_s2_q) rx_done   = 1'b1;
          else         rx_ferr_d = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Holding register: a simultaneous consume makes room for the new byte.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = 1'b0;
    if (rx_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sh_q    <= rx_sh_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_ferr    = rx_ferr_q;
  assign rx_overrun = rx_ovr_q;

  // ---------------------------------------------------------------- TX ----
  tx_state_t            tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [BIT_IDX_W-1:0] tx_bit_q, tx_bit_d;
  logic                 tx_stop_q, tx_stop_d;
  logic                 tty_tx_q, tty_tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 tx_ld, tx_tc;

  kim_bit_timer #(.W(CNT_W)) u_tx_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tx_ld),
    .load_val (FULL_LD),
    .tc       (tx_tc)
  );

  // The line level is registered and changes on the same edge the timer is
  // reloaded, so every bit lasts exactly BIT_CYCLES.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tty_tx_d   = tty_tx_q;
    tx_ready_d = tx_ready_q;
    tx_busy_d  = tx_busy_q;
    tx_ld      = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_d = TX_START;
          tx_sh_d    = tx_data;
          tty_tx_d   = 1'b0;
          tx_ready_d = 1'b0;
          tx_busy_d  = 1'b1;
          tx_ld      = 1'b1;
        end
      end
      TX_START: begin
        if (tx_tc) begin
          tx_state_d = TX_DATA;
          tty_tx_d   = tx_sh_q[0];
          tx_sh_d    = tx_sh_q >> 1;
          tx_bit_d   = '0;
          tx_ld      = 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_tc) begin
          tx_ld = 1'b1;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = TX_STOP;
            tty_tx_d   = 1'b1;
            tx_stop_d  = 1'b0;
          end else begin
            tty_tx_d = tx_sh_q[0];
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tx_tc) begin
          if (tx_stop_q == LAST_STOP) begin
            tx_state_d = TX_IDLE;
            tx_ready_d = 1'b1;
            tx_busy_d  = 1'b0;
          end else begin
            tx_stop_d = tx_stop_q + 1'b1;
            tx_ld     = 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tty_tx_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tty_tx_q   <= tty_tx_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign tty_tx   = tty_tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_kim_tty_bridge.sv
// Bench for kim_tty_bridge at BIT_CYCLES=8, STOP_BITS=2. A frame-level model
// (line level as a function of time since handshake; RX completions queued
// with their due cycle) is compared against the DUT on every negedge.
module tb_kim_tty_bridge;

  localparam int B     = 8;
  localparam int SB    = 2;
  localparam int FRAME = (9 + SB) * B;

  logic       clk = 1'b0, reset = 1'b0, tty_rx = 1'b1, rx_ready = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tty_tx, rx_valid, rx_ferr, rx_overrun, tx_ready, tx_busy;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  kim_tty_bridge #(.BIT_CYCLES(B), .STOP_BITS(SB)) dut (
    .clk(clk), .reset(reset), .tty_rx(tty_rx), .tty_tx(tty_tx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_ferr(rx_ferr), .rx_overrun(rx_overrun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy)
  );

  int n_pass = 0, n_chk = 0;
  int cyc = 0, lat = 78, first_v = -1, ferr_cnt = 0, ovr_cnt = 0;
  bit cmp_en = 0, cal_done = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ------------------------------------------------------------ model ----
  typedef struct { int t; logic [7:0] b; bit ok; } rxf_t;
  rxf_t       rxq[$];
  bit         m_v = 0, m_fe = 0, m_ov = 0;
  logic [7:0] m_d = 8'h00;
  bit         tx_act = 0;
  int         tx_h = 0;
  logic [7:0] tx_b = 8'h00;

  function automatic logic tx_line(int k, logic [7:0] b);
    int idx = k / B;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  function automatic bit tx_busy_at(int c);
    return tx_act && (c - tx_h) >= 0 && (c - tx_h) < FRAME;
  endfunction

  always @(posedge clk) begin
    rxf_t f;
    cyc = cyc + 1;
    if (!reset) begin
      m_v = 0; m_d = 8'h00; m_fe = 0; m_ov = 0; tx_act = 0;
      rxq.delete();
    end else begin
      m_fe = 0; m_ov = 0;
      if (rxq.size() > 0 && rxq[0].t == cyc) begin
        f = rxq.pop_front();
        if (!f.ok)                  m_fe = 1;
        else if (!m_v || rx_ready) begin m_d = f.b; m_v = 1; end
        else                        m_ov = 1;
      end else if (m_v && rx_ready) begin
        m_v = 0;
      end
      if (tx_valid && !tx_busy_at(cyc - 1)) begin
        tx_act = 1; tx_h = cyc; tx_b = tx_data;
      end
    end
  end

  // ---------------------------------------------------------- compare ----
  always @(negedge clk) begin
    if (rx_ferr) ferr_cnt++;
    if (rx_overrun) ovr_cnt++;
    if (rx_valid && first_v < 0) first_v = cyc;
    if (cmp_en) begin
      if (!reset) begin
        chk("tty_tx_rst", tty_tx, 1); chk("tx_ready_rst", tx_ready, 1);
        chk("tx_busy_rst", tx_busy, 0); chk("rx_valid_rst", rx_valid, 0);
        chk("rx_data_rst", rx_data, 0); chk("rx_ferr_rst", rx_ferr, 0);
        chk("rx_overrun_rst", rx_overrun, 0);
      end else begin
        chk("tty_tx", tty_tx, tx_busy_at(cyc) ? tx_line(cyc - tx_h, tx_b) : 1'b1);
        chk("tx_ready", tx_ready, !tx_busy_at(cyc));
        chk("tx_busy", tx_busy, tx_busy_at(cyc));
        if (cal_done) begin
          chk("rx_valid", rx_valid, m_v);
          chk("rx_data", rx_data, m_d);
          chk("rx_ferr", rx_ferr, m_fe);
          chk("rx_overrun", rx_overrun, m_ov);
        end
      end
    end
  end

  // -------------------------------------------------------- stimulus ----
  // Called right after a negedge; the first posedge to see the start bit is cyc+1.
  task automatic send_rx(input logic [7:0] b, input bit ok, input bit track);
    if (track) rxq.push_back('{t: cyc + 1 + lat, b: b, ok: ok});
    tty_rx = 1'b0; repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin tty_rx = b[i]; repeat (B) @(negedge clk); end
    tty_rx = ok; repeat (B) @(negedge clk);
    tty_rx = 1'b1;
    if (!ok) repeat (B) @(negedge clk);
  endtask

  task automatic consume();
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
  endtask

  // Sends one byte and returns the 11 mid-bit line samples.
  task automatic send_tx(input logic [7:0] b, output logic [10:0] seen, output int low);
    tx_data = b; tx_valid = 1'b1; @(negedge clk); tx_valid = 1'b0;
    low = 0; seen = '0;
    for (int k = 0; k < FRAME; k++) begin
      if (k % B == B / 2) seen[k / B] = tty_tx;
      if (!tx_ready) low++;
      if (k == 20) begin tx_data = 8'hEE; tx_valid = 1'b1; end   // ignored while busy
      if (k == 21) tx_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int         e1, t2, f0, o0, low;
    bit         drop;
    bit         rx_fin;
    logic [10:0] seen;
    bit         exp0d[11] = '{0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1};

    cmp_en = 1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Calibrate RX latency from the 0x55 frame, then hold the model to it.
    f0 = ferr_cnt; o0 = ovr_cnt; e1 = cyc + 1;
    send_rx(8'h55, 1, 0);
    for (int i = 0; i < 20 && first_v < 0; i++) @(negedge clk);
    chk("rx_lat_window", (first_v - e1 >= 77 && first_v - e1 <= 80), 1);
    if (first_v - e1 >= 77 && first_v - e1 <= 80) lat = first_v - e1;
    chk("rx_55_data", rx_data, 8'h55);
    chk("rx_55_valid", rx_valid, 1);
    chk("rx_55_noerr", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    m_v = 1; m_d = 8'h55; cal_done = 1;
    consume();
    repeat (2) @(negedge clk);

    // Short glitch is not a start bit.
    f0 = ferr_cnt;
    tty_rx = 1'b0; repeat (2) @(negedge clk); tty_rx = 1'b1;
    repeat (3 * B) @(negedge clk);
    chk("glitch_noferr", ferr_cnt - f0, 0);
    chk("glitch_novalid", rx_valid, 0);

    // Framing error.
    f0 = ferr_cnt;
    send_rx(8'hA3, 0, 1);
    repeat (4) @(negedge clk);
    chk("ferr_once", ferr_cnt - f0, 1);
    chk("ferr_novalid", rx_valid, 0);

    // Overrun keeps the older byte.
    o0 = ovr_cnt;
    send_rx(8'h11, 1, 1);
    send_rx(8'h22, 1, 1);
    repeat (4) @(negedge clk);
    chk("ovr_keep_data", rx_data, 8'h11);
    chk("ovr_once", ovr_cnt - o0, 1);
    chk("ovr_valid", rx_valid, 1);
    consume();
    repeat (2) @(negedge clk);

    // Consume in exactly the completion cycle of the second byte.
    o0 = ovr_cnt; drop = 0;
    send_rx(8'h11, 1, 1);
    t2 = cyc + 1 + lat;
    fork
      send_rx(8'h22, 1, 1);
      begin
        while (cyc < t2 - 1) begin if (!rx_valid) drop = 1; @(negedge clk); end
        rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
        if (!rx_valid) drop = 1;
      end
    join
    chk("held_data", rx_data, 8'h22);
    chk("held_no_drop", drop, 0);
    chk("held_no_ovr", ovr_cnt - o0, 0);
    consume();

    // TX 0x0D literal waveform.
    send_tx(8'h0D, seen, low);
    for (int i = 0; i < 11; i++) chk($sformatf("tx0d_bit%0d", i), seen[i], exp0d[i]);
    chk("tx0d_ready_low", low, FRAME);
    chk("tx0d_ready_back", tx_ready, 1);

    // Reset in the middle of a TX data bit, with an RX byte held.
    send_rx(8'h3C, 1, 1);
    tx_data = 8'hA5; tx_valid = 1'b1; @(negedge clk); tx_valid = 1'b0;
    repeat (2 * B + B / 2) @(negedge clk);
    chk("pre_rst_tty_low", tty_tx, 0);
    chk("pre_rst_rx_valid", rx_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_tty", tty_tx, 1);
    chk("rst_async_ready", tx_ready, 1);
    chk("rst_async_rxv", rx_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_tx(8'h7F, seen, low);
    chk("tx7f_start", seen[0], 0);
    chk("tx7f_data", seen[8:1], 8'h7F);
    chk("tx7f_stop", seen[10:9], 2'b11);

    // Randomized traffic on both directions at once.
    rx_fin = 0;
    fork
      begin
        for (int n = 0; n < 25; n++) begin
          send_rx(8'($urandom), $urandom_range(9) != 0, 1);
          repeat ($urandom_range(B)) @(negedge clk);
        end
        rx_fin = 1;
      end
      begin
        while (!rx_fin) begin rx_ready = 1'($urandom_range(1)); @(negedge clk); end
        rx_ready = 1'b0;
      end
      begin
        while (!rx_fin) begin
          tx_valid = ($urandom_range(3) == 0); tx_data = 8'($urandom);
          @(negedge clk);
        end
        tx_valid = 1'b0;
      end
    join
    repeat (FRAME + 10) @(negedge clk);
    chk("rxq_drained", rxq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
